// File: rtl/membus_id_arbiter_if.sv
// Membus bundle between the core fetch/data ports, the arbiter and the merged master side.
// slave = arbiter view, master = environment (core + mmio_controller) view.
interface membus_id_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 64
);
    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;

    logic                  i_valid;
    logic                  i_ready;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_rvalid;
    logic [DATA_WIDTH-1:0] i_rdata;

    logic                  d_valid;
    logic                  d_ready;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic                  d_wen;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [MASK_WIDTH-1:0] d_wmask;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  m_valid;
    logic                  m_ready;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic                  m_wen;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic [MASK_WIDTH-1:0] m_wmask;
    logic                  m_rvalid;
    logic [DATA_WIDTH-1:0] m_rdata;

    modport slave (
        input  i_valid, i_addr,
        input  d_valid, d_addr, d_wen, d_wdata, d_wmask,
        input  m_ready, m_rvalid, m_rdata,
        output i_ready, i_rvalid, i_rdata,
        output d_ready, d_rvalid, d_rdata,
        output m_valid, m_addr, m_wen, m_wdata, m_wmask
    );

    modport master (
        output i_valid, i_addr,
        output d_valid, d_addr, d_wen, d_wdata, d_wmask,
        output m_ready, m_rvalid, m_rdata,
        input  i_ready, i_rvalid, i_rdata,
        input  d_ready, d_rvalid, d_rdata,
        input  m_valid, m_addr, m_wen, m_wdata, m_wmask
    );
endinterface

// File: rtl/membus_id_arbiter.sv
// Fetch/data Membus merger with in-order response routing via a tag FIFO and a fetch starvation guard.
// Define ID_ARB_PERF_EN to add the perf_i_grants / perf_d_grants / perf_stall_cycles counters.
module membus_id_arbiter #(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STARVE_LIMIT    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    membus_id_arbiter_if.slave        bus,
    output logic                      err_orphan
`ifdef ID_ARB_PERF_EN
    ,
    output logic [31:0]               perf_i_grants,
    output logic [31:0]               perf_d_grants,
    output logic [31:0]               perf_stall_cycles
`endif
);
    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned PTR_W      = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W      = PTR_W + 1;
    localparam int unsigned STV_W      = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [STV_W-1:0]           starve_q, starve_d;
    logic                       err_q, err_d;

    logic full, starved, sel_i, req_ok, accept, pop, fifo_empty;

    // Grant selection, handshakes and payload mux
    always_comb begin
        fifo_empty = (count_q == CNT_W'(0));
        full       = (count_q == CNT_W'(MAX_OUTSTANDING));
        starved    = (STARVE_LIMIT != 0) && (starve_q >= STV_W'(STARVE_LIMIT));
        sel_i      = bus.i_valid & (~bus.d_valid | starved);
        req_ok     = ~rst & ~full;
        accept     = req_ok & (bus.i_valid | bus.d_valid) & bus.m_ready;
        pop        = ~rst & bus.m_rvalid & ~fifo_empty;

        bus.m_valid = req_ok & (bus.i_valid | bus.d_valid);
        bus.i_ready = req_ok & bus.m_ready & sel_i;
        bus.d_ready = req_ok & bus.m_ready & bus.d_valid & ~sel_i;

        bus.m_addr  = ADDR_WIDTH'(bus.d_addr);
        bus.m_wen   = bus.d_wen;
        bus.m_wdata = DATA_WIDTH'(bus.d_wdata);
        bus.m_wmask = MASK_WIDTH'(bus.d_wmask);
        if (sel_i) begin
            bus.m_addr  = ADDR_WIDTH'(bus.i_addr);
            bus.m_wen   = 1'b0;
            bus.m_wdata = DATA_WIDTH'(0);
            bus.m_wmask = MASK_WIDTH'(0);
        end

        bus.i_rvalid = pop & tag_q[rd_ptr_q];
        bus.d_rvalid = pop & ~tag_q[rd_ptr_q];
        bus.i_rdata  = bus.m_rdata;
        bus.d_rdata  = bus.m_rdata;
    end

    // Tag FIFO, starvation counter and orphan flag next state
    always_comb begin
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        err_d    = err_q;

        if (accept) begin
            tag_d[wr_ptr_q] = sel_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (!bus.i_valid || (accept && sel_i)) begin
            starve_d = STV_W'(0);
        end else if (accept && (starve_q < STV_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STV_W'(1);
        end

        if (bus.m_rvalid && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    assign err_orphan = err_q;

`ifdef ID_ARB_PERF_EN
    logic [31:0] perf_i_q, perf_i_d;
    logic [31:0] perf_d_q, perf_d_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Free-running grant and stall counters, wrapping at 2^32
    always_comb begin
        perf_i_d     = perf_i_q;
        perf_d_d     = perf_d_q;
        perf_stall_d = perf_stall_q;
        if (accept && sel_i)  perf_i_d = perf_i_q + 32'(1);
        if (accept && !sel_i) perf_d_d = perf_d_q + 32'(1);
        if ((bus.i_valid || bus.d_valid) && !accept) perf_stall_d = perf_stall_q + 32'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_i_q     <= '0;
            perf_d_q     <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_i_q     <= perf_i_d;
            perf_d_q     <= perf_d_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_i_grants     = perf_i_q;
    assign perf_d_grants     = perf_d_q;
    assign perf_stall_cycles = perf_stall_q;
`endif
endmodule

// File: tb/tb_membus_id_arbiter.sv
// Directed bench for membus_id_arbiter: routing, priority, outstanding limit, starvation, orphan/reset.
module tb_membus_id_arbiter;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_orphan;
`ifdef ID_ARB_PERF_EN
    logic [31:0] perf_i_grants, perf_d_grants, perf_stall_cycles;
`endif

    always #5 clk = ~clk;

    membus_id_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    membus_id_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(4), .STARVE_LIMIT(8)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .err_orphan       (err_orphan)
`ifdef ID_ARB_PERF_EN
        ,
        .perf_i_grants    (perf_i_grants),
        .perf_d_grants    (perf_d_grants),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_valid  = 1'b0;
        bus.i_addr   = '0;
        bus.d_valid  = 1'b0;
        bus.d_addr   = '0;
        bus.d_wen    = 1'b0;
        bus.d_wdata  = '0;
        bus.d_wmask  = '0;
        bus.m_ready  = 1'b0;
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = '0;
    endtask

    initial begin
        // Reset: all handshake outputs gated even with every input active
        idle();
        rst = 1'b1;
        bus.i_valid = 1'b1; bus.d_valid = 1'b1; bus.m_ready = 1'b1; bus.m_rvalid = 1'b1;
        #1;
        check_eq("rst_m_valid", 64'(bus.m_valid), 64'd0);
        check_eq("rst_i_ready", 64'(bus.i_ready), 64'd0);
        check_eq("rst_d_ready", 64'(bus.d_ready), 64'd0);
        check_eq("rst_i_rvalid", 64'(bus.i_rvalid), 64'd0);
        check_eq("rst_d_rvalid", 64'(bus.d_rvalid), 64'd0);
        cyc();
        check_eq("rst_err_orphan", 64'(err_orphan), 64'd0);
        idle();
        rst = 1'b0;
        bus.m_ready = 1'b1;

        // 1: lone fetch
        bus.i_valid = 1'b1; bus.i_addr = 64'h8000_0000;
        #1;
        check_eq("s1_m_valid", 64'(bus.m_valid), 64'd1);
        check_eq("s1_i_ready", 64'(bus.i_ready), 64'd1);
        check_eq("s1_d_ready", 64'(bus.d_ready), 64'd0);
        check_eq("s1_m_addr", bus.m_addr, 64'h8000_0000);
        check_eq("s1_m_wen", 64'(bus.m_wen), 64'd0);
        cyc();
        bus.i_valid = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 64'h13;
        #1;
        check_eq("s1_i_rvalid", 64'(bus.i_rvalid), 64'd1);
        check_eq("s1_i_rdata", bus.i_rdata, 64'h13);
        check_eq("s1_d_rvalid", 64'(bus.d_rvalid), 64'd0);
        cyc();
        bus.m_rvalid = 1'b0;

        // 2: conflict, data store first then fetch, responses D then I
        bus.i_valid = 1'b1; bus.i_addr = 64'h8000_0004;
        bus.d_valid = 1'b1; bus.d_addr = 64'h8000_1000; bus.d_wen = 1'b1;
        bus.d_wdata = 64'h1122_3344_5566_7788; bus.d_wmask = 8'hFF;
        #1;
        check_eq("s2_d_ready", 64'(bus.d_ready), 64'd1);
        check_eq("s2_i_ready_blocked", 64'(bus.i_ready), 64'd0);
        check_eq("s2_m_wen_d", 64'(bus.m_wen), 64'd1);
        check_eq("s2_m_addr_d", bus.m_addr, 64'h8000_1000);
        check_eq("s2_m_wmask_d", 64'(bus.m_wmask), 64'hFF);
        check_eq("s2_m_wdata_d", bus.m_wdata, 64'h1122_3344_5566_7788);
        cyc();
        bus.d_valid = 1'b0;
        #1;
        check_eq("s2_i_ready", 64'(bus.i_ready), 64'd1);
        check_eq("s2_m_addr_i", bus.m_addr, 64'h8000_0004);
        check_eq("s2_m_wen_i", 64'(bus.m_wen), 64'd0);
        check_eq("s2_m_wmask_i", 64'(bus.m_wmask), 64'd0);
        check_eq("s2_m_wdata_i", bus.m_wdata, 64'd0);
        cyc();
        bus.i_valid = 1'b0; bus.d_wen = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 64'hAA;
        #1;
        check_eq("s2_rsp1_d_rvalid", 64'(bus.d_rvalid), 64'd1);
        check_eq("s2_rsp1_i_rvalid", 64'(bus.i_rvalid), 64'd0);
        check_eq("s2_rsp1_d_rdata", bus.d_rdata, 64'hAA);
        cyc();
        bus.m_rdata = 64'hBB;
        #1;
        check_eq("s2_rsp2_i_rvalid", 64'(bus.i_rvalid), 64'd1);
        check_eq("s2_rsp2_d_rvalid", 64'(bus.d_rvalid), 64'd0);
        check_eq("s2_rsp2_i_rdata", bus.i_rdata, 64'hBB);
        cyc();
        bus.m_rvalid = 1'b0;

        // 3: outstanding limit, then one response frees a slot for the next cycle
        bus.i_valid = 1'b1; bus.i_addr = 64'h8000_0100;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("s3_fill_i_ready", 64'(bus.i_ready), 64'd1);
            cyc();
        end
        bus.d_valid = 1'b1; bus.d_addr = 64'h8000_2000;
        bus.m_rvalid = 1'b1; bus.m_rdata = 64'h55;
        #1;
        check_eq("s3_full_m_valid", 64'(bus.m_valid), 64'd0);
        check_eq("s3_full_i_ready", 64'(bus.i_ready), 64'd0);
        check_eq("s3_full_d_ready", 64'(bus.d_ready), 64'd0);
        check_eq("s3_full_i_rvalid", 64'(bus.i_rvalid), 64'd1);
        cyc();
        bus.m_rvalid = 1'b0;
        #1;
        check_eq("s3_freed_m_valid", 64'(bus.m_valid), 64'd1);
        check_eq("s3_freed_d_ready", 64'(bus.d_ready), 64'd1);
        check_eq("s3_freed_i_ready", 64'(bus.i_ready), 64'd0);
        cyc();
        bus.i_valid = 1'b0; bus.d_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.m_rvalid = 1'b1;
            #1;
            check_eq("s3_drain_i_rvalid", 64'(bus.i_rvalid), (k < 3) ? 64'd1 : 64'd0);
            check_eq("s3_drain_d_rvalid", 64'(bus.d_rvalid), (k == 3) ? 64'd1 : 64'd0);
            cyc();
        end
        bus.m_rvalid = 1'b0;

        // 4: starvation guard, 8 D grants then 1 I grant then D again
        bus.i_valid = 1'b1; bus.d_valid = 1'b1; bus.d_wen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.m_rvalid = (k > 0);
            #1;
            check_eq("s4_i_ready", 64'(bus.i_ready), (k == 8) ? 64'd1 : 64'd0);
            check_eq("s4_d_ready", 64'(bus.d_ready), (k == 8) ? 64'd0 : 64'd1);
            if (k > 0) check_eq("s4_i_rvalid", 64'(bus.i_rvalid), (k == 9) ? 64'd1 : 64'd0);
            cyc();
        end
        bus.i_valid = 1'b0; bus.d_valid = 1'b0; bus.m_rvalid = 1'b1;
        #1;
        check_eq("s4_last_d_rvalid", 64'(bus.d_rvalid), 64'd1);
        cyc();
        bus.m_rvalid = 1'b0;

        // 5: orphan response, then reset discards outstanding tags
        bus.m_rvalid = 1'b1;
        #1;
        check_eq("s5_orphan_i_rvalid", 64'(bus.i_rvalid), 64'd0);
        check_eq("s5_orphan_d_rvalid", 64'(bus.d_rvalid), 64'd0);
        cyc();
        bus.m_rvalid = 1'b0;
        #1;
        check_eq("s5_err_set", 64'(err_orphan), 64'd1);
        bus.i_valid = 1'b1;
        cyc();
        cyc();
        bus.i_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        check_eq("s5_err_cleared", 64'(err_orphan), 64'd0);
        bus.m_rvalid = 1'b1;
        #1;
        check_eq("s5_post_rst_i_rvalid", 64'(bus.i_rvalid), 64'd0);
        cyc();
        bus.m_rvalid = 1'b0;
        #1;
        check_eq("s5_post_rst_err", 64'(err_orphan), 64'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;

`ifdef ID_ARB_PERF_EN
        // 6: conflict pair followed by a 3-cycle downstream stall
        check_eq("s6_perf_reset", 64'(perf_i_grants), 64'd0);
        bus.i_valid = 1'b1; bus.d_valid = 1'b1; bus.d_wen = 1'b1;
        cyc();
        bus.d_valid = 1'b0; bus.d_wen = 1'b0;
        cyc();
        bus.i_valid = 1'b0; bus.m_rvalid = 1'b1;
        cyc();
        cyc();
        bus.m_rvalid = 1'b0; bus.m_ready = 1'b0; bus.i_valid = 1'b1;
        cyc();
        cyc();
        cyc();
        bus.i_valid = 1'b0;
        #1;
        check_eq("s6_perf_i_grants", 64'(perf_i_grants), 64'd1);
        check_eq("s6_perf_d_grants", 64'(perf_d_grants), 64'd1);
        check_eq("s6_perf_stall_cycles", 64'(perf_stall_cycles), 64'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
